// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and rotating priority pointer.
// Optional hold-time preemption is compiled in with the ARB_TIMEOUT_EN macro.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gntIdx,
  output logic       gntValid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] pick;
  logic [1:0] idx_nxt;
  logic [3:0] gnt_nxt;
  logic       valid_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       hit_limit;
  logic       release_now;
  logic       timeout_nxt;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be in 1..255");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  assign hit_limit = (state == GRANT) && (hold_cnt == HOLD_LIMIT);
`else
  assign hit_limit = 1'b0;
`endif

  // Scan from ptr upward; iterating the offsets high-to-low lets the nearest request win.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    idx_nxt     = gntIdx;
    gnt_nxt     = gnt;
    valid_nxt   = gntValid;
    timeout_nxt = 1'b0;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          idx_nxt   = pick;
          gnt_nxt   = 4'b0001 << pick;
          valid_nxt = 1'b1;
          hold_nxt  = 8'd1;
        end
      end
      GRANT: begin
        release_now = done || !req[gntIdx] || hit_limit;
        if (release_now) begin
          state_nxt   = IDLE;
          idx_nxt     = 2'd0;
          gnt_nxt     = 4'b0000;
          valid_nxt   = 1'b0;
          ptr_nxt     = gntIdx + 2'd1;
          hold_nxt    = 8'd0;
          timeout_nxt = hit_limit;
        end else if (hold_cnt != 8'hFF) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt      <= 4'b0000;
      gntIdx   <= 2'd0;
      gntValid <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gntIdx   <= idx_nxt;
      gntValid <= valid_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule
